// File: rtl/ysyx_23060184_mem_ctrl.sv
// MEM-stage controller: sequences one data-memory transaction per
// load/store, aligns store data, extends load data, flags faults.
module ysyx_23060184_mem_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [3:0]            WmaskM,
  input  logic [2:0]            RopcodeM,
  input  logic                  Wready,
  output logic                  Mready,
  output logic                  Mvalid,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  Mfault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic                  mem_err,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, nextState;

  logic                  accept;
  logic                  isStore;
  logic                  isLoad;
  logic                  misLoad;
  logic                  misStore;
  logic                  misAlign;
  logic                  needMem;
  logic [DATA_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic [3:0]            wmaskQ;
  logic [2:0]            ropQ;
  logic                  weQ;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] loadExt;

  assign accept  = in_valid & Mready;
  assign isStore = MemWriteM;
  assign isLoad  = MemReadM & ~MemWriteM;

  assign misLoad =
    ((RopcodeM == 3'd1 || RopcodeM == 3'd5) && ALUResultM[0]) ||
    (RopcodeM == 3'd2 && ALUResultM[1:0] != 2'b00);
  assign misStore =
    (WmaskM == 4'h3 && ALUResultM[0]) ||
    (WmaskM == 4'hF && ALUResultM[1:0] != 2'b00);

  assign misAlign = isStore ? misStore : (isLoad & misLoad);
  assign needMem  = (isStore | isLoad) & ~misAlign;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept) nextState = needMem ? REQ : DONE;
      REQ:  if (mem_ack) nextState = DONE;
      DONE: begin
        if (accept)      nextState = needMem ? REQ : DONE;
        else if (Wready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Mready  = (state == IDLE) | ((state == DONE) & Wready);
    Mvalid  = (state == DONE);
    mem_req = (state == REQ);
  end

  assign shifted = mem_rdata >> {addrQ[1:0], 3'b000};

  always_comb begin
    loadExt = shifted;
    case (ropQ)
      3'd0: loadExt = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'd1: loadExt = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'd4: loadExt = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'd5: loadExt = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: loadExt = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ     <= '0;
      wdataQ    <= '0;
      wmaskQ    <= '0;
      ropQ      <= '0;
      weQ       <= 1'b0;
      ReadDataM <= '0;
      Mfault    <= 1'b0;
    end else if (accept) begin
      addrQ     <= ALUResultM;
      wdataQ    <= WriteDataM;
      wmaskQ    <= WmaskM;
      ropQ      <= RopcodeM;
      weQ       <= isStore;
      ReadDataM <= '0;
      Mfault    <= misAlign;
    end else if (state == REQ && mem_ack) begin
      ReadDataM <= (mem_err | weQ) ? '0 : loadExt;
      Mfault    <= mem_err;
    end
  end

  // Request fields come only from captured state, so they hold until ack.
  assign mem_we    = weQ;
  assign mem_addr  = {addrQ[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdataQ << {addrQ[1:0], 3'b000};
  assign mem_wstrb = weQ ? (wmaskQ << addrQ[1:0]) : 4'h0;

endmodule

// File: tb/tb_ysyx_23060184_mem_ctrl.sv
// Bench for ysyx_23060184_mem_ctrl: directed scenarios plus random
// traffic against a transaction-level model.
module tb_ysyx_23060184_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  WmaskM;
  logic [2:0]  RopcodeM;
  logic        Wready;
  logic        Mready;
  logic        Mvalid;
  logic [31:0] ReadDataM;
  logic        Mfault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model: one held instruction, either waiting on memory or holding a result.
  bit          mBusy;
  bit          mPend;
  bit          mWe;
  logic [31:0] mAddr;
  logic [31:0] mWd;
  logic [3:0]  mStrb;
  logic [1:0]  mLow;
  logic [2:0]  mOp;
  logic [31:0] mRes;
  bit          mFault;

  ysyx_23060184_mem_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .MemReadM(MemReadM),
    .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .WmaskM(WmaskM),
    .RopcodeM(RopcodeM),
    .Wready(Wready),
    .Mready(Mready),
    .Mvalid(Mvalid),
    .ReadDataM(ReadDataM),
    .Mfault(Mfault),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack),
    .mem_err(mem_err),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned loadSize(input logic [2:0] op);
    int unsigned k;
    k = op % 4;
    if (k == 0) return 1;
    if (k == 1) return 2;
    return 4;
  endfunction

  function automatic int unsigned storeSize(input logic [3:0] m);
    if (m == 4'h3) return 2;
    if (m == 4'hF) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] extLoad(input logic [31:0] rd,
                                          input logic [1:0] a,
                                          input logic [2:0] op);
    int unsigned v;
    v = rd / (32'd1 << (8 * a));
    case (op)
      3'd0: begin v = v % 256; if (v >= 128) v = v + 32'hFFFFFF00; end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  function automatic bit expRdy();
    return !mBusy || (!mPend && Wready);
  endfunction

  task automatic compare();
    chk("Mready", {31'd0, Mready}, {31'd0, expRdy()});
    chk("Mvalid", {31'd0, Mvalid}, {31'd0, mBusy && !mPend});
    chk("mem_req", {31'd0, mem_req}, {31'd0, mBusy && mPend});
    if (mBusy && mPend) begin
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, mWe});
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, mStrb});
      if (mWe) chk("mem_wdata", mem_wdata, mWd);
    end
    if (mBusy && !mPend) begin
      chk("ReadDataM", ReadDataM, mRes);
      chk("Mfault", {31'd0, Mfault}, {31'd0, mFault});
    end
  endtask

  task automatic cycle();
    bit acc;
    bit st;
    bit ld;
    bit mis;
    int unsigned a;
    @(negedge clk);
    compare();
    acc = in_valid && expRdy();
    @(posedge clk);
    if (reset) begin
      mBusy = 0;
      mPend = 0;
    end else if (mBusy && mPend && mem_ack) begin
      mPend  = 0;
      mFault = mem_err;
      mRes   = (mem_err || mWe) ? 32'd0 : extLoad(mem_rdata, mLow, mOp);
    end else if (acc) begin
      a   = ALUResultM % 4;
      st  = MemWriteM;
      ld  = MemReadM && !MemWriteM;
      mis = st ? (ALUResultM % storeSize(WmaskM) != 0)
               : (ld && (ALUResultM % loadSize(RopcodeM) != 0));
      mBusy  = 1;
      mPend  = (st || ld) && !mis;
      mWe    = st;
      mAddr  = ALUResultM - a;
      mWd    = WriteDataM * (32'd1 << (8 * a));
      mStrb  = st ? 4'((WmaskM * (1 << a)) % 16) : 4'h0;
      mLow   = 2'(a);
      mOp    = RopcodeM;
      mRes   = 32'd0;
      mFault = mis;
    end else if (mBusy && !mPend && Wready) begin
      mBusy = 0;
    end
    #1;
  endtask

  task automatic clearIn();
    in_valid   = 0;
    MemReadM   = 0;
    MemWriteM  = 0;
    ALUResultM = 0;
    WriteDataM = 0;
    WmaskM     = 0;
    RopcodeM   = 0;
    mem_ack    = 0;
    mem_err    = 0;
    mem_rdata  = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] op);
    clearIn();
    in_valid   = 1;
    MemReadM   = 1;
    ALUResultM = addr;
    RopcodeM   = op;
  endtask

  initial begin
    logic [31:0] hold;
    clearIn();
    reset  = 1;
    Wready = 1;
    mBusy  = 0;
    mPend  = 0;
    @(posedge clk);
    #1;
    cycle();
    reset = 0;
    #1;
    chk("rst Mready", {31'd0, Mready}, 32'd1);
    chk("rst Mvalid", {31'd0, Mvalid}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst ReadDataM", ReadDataM, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle mem_req", {31'd0, mem_req}, 32'd0);
    end

    for (int k = 0; k < 2; k++) begin
      load(32'h80000003, k == 0 ? 3'd0 : 3'd4);
      cycle();
      clearIn();
      chk("lb mem_req", {31'd0, mem_req}, 32'd1);
      chk("lb mem_addr", mem_addr, 32'h80000000);
      mem_ack   = 1;
      mem_rdata = 32'h80ABCDEF;
      cycle();
      clearIn();
      chk("lb Mvalid", {31'd0, Mvalid}, 32'd1);
      chk("lb ReadDataM", ReadDataM, k == 0 ? 32'hFFFFFF80 : 32'h00000080);
      chk("lb Mfault", {31'd0, Mfault}, 32'd0);
      cycle();
    end

    clearIn();
    in_valid   = 1;
    MemWriteM  = 1;
    ALUResultM = 32'h80000002;
    WriteDataM = 32'h1234;
    WmaskM     = 4'h3;
    cycle();
    clearIn();
    for (int k = 0; k < 4; k++) begin
      chk("sh mem_wstrb", {28'd0, mem_wstrb}, 32'hC);
      chk("sh mem_wdata", mem_wdata, 32'h12340000);
      chk("sh mem_we", {31'd0, mem_we}, 32'd1);
      mem_ack = (k == 3);
      cycle();
    end
    clearIn();
    chk("sh Mvalid", {31'd0, Mvalid}, 32'd1);
    chk("sh ReadDataM", ReadDataM, 32'd0);
    cycle();

    load(32'h80000001, 3'd2);
    cycle();
    clearIn();
    chk("mis mem_req", {31'd0, mem_req}, 32'd0);
    chk("mis Mvalid", {31'd0, Mvalid}, 32'd1);
    chk("mis Mfault", {31'd0, Mfault}, 32'd1);
    cycle();

    load(32'h80000004, 3'd2);
    cycle();
    clearIn();
    mem_ack   = 1;
    mem_err   = 1;
    mem_rdata = 32'hFFFFFFFF;
    cycle();
    clearIn();
    chk("err Mfault", {31'd0, Mfault}, 32'd1);
    chk("err ReadDataM", ReadDataM, 32'd0);
    cycle();

    for (int k = 0; k < 3; k++) begin
      clearIn();
      in_valid   = 1;
      ALUResultM = 32'h11 * k;
      cycle();
    end
    load(32'h00000100, 3'd2);
    cycle();
    clearIn();
    Wready    = 0;
    mem_ack   = 1;
    mem_rdata = 32'hDEADBEEF;
    cycle();
    clearIn();
    hold = ReadDataM;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b2b Mready", {31'd0, Mready}, 32'd0);
      chk("b2b hold", ReadDataM, 32'hDEADBEEF);
      cycle();
      chk("b2b stable", ReadDataM, hold);
    end
    Wready   = 1;
    in_valid = 1;
    #1;
    chk("b2b chain Mready", {31'd0, Mready}, 32'd1);
    cycle();
    clearIn();
    chk("b2b chain Mvalid", {31'd0, Mvalid}, 32'd1);
    chk("b2b chain data", ReadDataM, 32'd0);
    cycle();

    load(32'h00000200, 3'd2);
    cycle();
    clearIn();
    reset = 1;
    cycle();
    reset = 0;
    chk("rstreq mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstreq Mvalid", {31'd0, Mvalid}, 32'd0);
    mem_ack = 1;
    cycle();
    mem_ack = 0;
    chk("stray Mvalid", {31'd0, Mvalid}, 32'd0);
    cycle();

    for (int i = 0; i < 4000; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      MemReadM   = $urandom_range(0, 1) != 0;
      MemWriteM  = $urandom_range(0, 2) == 0;
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      case ($urandom_range(0, 2))
        0:       WmaskM = 4'h1;
        1:       WmaskM = 4'h3;
        default: WmaskM = 4'hF;
      endcase
      case ($urandom_range(0, 4))
        0:       RopcodeM = 3'd0;
        1:       RopcodeM = 3'd1;
        2:       RopcodeM = 3'd2;
        3:       RopcodeM = 3'd4;
        default: RopcodeM = 3'd5;
      endcase
      Wready    = ($urandom_range(0, 9) < 7);
      mem_ack   = ($urandom_range(0, 9) < 4);
      mem_err   = ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
      reset     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_mem_ctrl.md
# ysyx_23060184_mem_ctrl

Memory-stage controller that sits behind the EX/MEM pipeline register and sequences the data-memory access for each instruction in MEM. It issues a single request/acknowledge transaction per load or store, aligns store data and byte strobes, extracts and extends load data, and flags misaligned or errored accesses. It generates the MEM-stage ready/valid handshake: `Mready` gates the EX/MEM register load, and `Mvalid`/`Wready` control hand-off to writeback.

## Interface
- DATA_WIDTH, 32, data and address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM register holds a fresh, unconsumed instruction
- MemReadM  in  1  instruction is a load
- MemWriteM  in  1  instruction is a store
- ALUResultM  in  DATA_WIDTH  effective address
- WriteDataM  in  DATA_WIDTH  store data, LSB-aligned
- WmaskM  in  4  store byte mask, LSB-aligned: 0x1 sb, 0x3 sh, 0xF sw
- RopcodeM  in  3  load funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
- Wready  in  1  writeback accepts the result
- Mready  out  1  controller accepts a new EX/MEM entry this cycle
- Mvalid  out  1  result is valid for writeback
- ReadDataM  out  DATA_WIDTH  extended load data; 0 for non-loads and faults
- Mfault  out  1  misaligned access or memory error; valid with Mvalid
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  DATA_WIDTH  store data shifted left by 8*addr[1:0]
- mem_wstrb  out  4  WmaskM shifted left by addr[1:0]; 0 on reads
- mem_ack  in  1  request completes this cycle
- mem_err  in  1  bus error; valid with mem_ack
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack

## Operation
- States: IDLE, REQ, DONE.
- `Mready` = (state==IDLE) | (state==DONE & Wready). Combinational. `Mvalid` = (state==DONE).
- Accept = in_valid & Mready. On accept, capture address, data, mask, and ropcode, then classify the access:
  - If the access is a store (MemWriteM set; a store wins if both are set) or a load, and it is aligned → REQ.
  - Otherwise → DONE. For a misaligned access, set Mfault=1 and issue no memory request. For a non-memory instruction, set Mfault=0.
- Misalignment rules:
  - Loads: lh/lhu with addr[0]=1, or lw with addr[1:0]≠0.
  - Stores: WmaskM=0x3 with addr[0]=1, or WmaskM=0xF with addr[1:0]≠0.
  - Byte accesses are never misaligned.
- In REQ, mem_req=1. mem_we, mem_addr, mem_wdata, and mem_wstrb are driven from the captured registers and stay stable until mem_ack.
- On mem_ack the controller moves to DONE:
  - mem_err=1: Mfault=1, ReadDataM=0.
  - Otherwise, for a load: ReadDataM = extend(mem_rdata >> 8*addr[1:0]). lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
  - Otherwise, for a store: ReadDataM=0.
- In DONE, `Mvalid`, ReadDataM, and Mfault hold until Wready:
  - Wready & in_valid: chain straight into the new access (REQ or DONE), with no IDLE bubble.
  - Wready & !in_valid: → IDLE.
- in_valid is ignored in REQ.
- mem_ack outside REQ is ignored.

## Timing
- Reset (synchronous): state=IDLE, mem_req=0, Mvalid=0, ReadDataM=0, Mfault=0, all captured registers=0. Combinationally, Mready=1 in IDLE.
- Reset while in REQ: mem_req drops at the reset edge and the outstanding transaction is abandoned. An ack arriving later lands in IDLE and is ignored.
- Non-memory and misaligned instructions: accept at edge T, Mvalid=1 after T. Latency 1.
- Loads and stores: accept at T, mem_req=1 after T. If mem_ack arrives in that same cycle, Mvalid=1 after T+1. Latency is 2 + wait cycles.
- Throughput with Wready held high:
  - Non-memory instructions: one per cycle.
  - Memory instructions with zero-wait memory: one every 2 cycles.
- mem_req is registered and never combinationally dependent on mem_ack.

## Test plan
- After reset: Mready=1, Mvalid=0, mem_req=0. Idle for 5 cycles → no mem_req.
- Load lb, addr 0x80000003, mem_rdata=0x80xxxxxx, ack on the first req cycle → mem_addr=0x80000000, Mvalid after 2 edges, ReadDataM=0xFFFFFF80, Mfault=0. Repeat with lbu → 0x00000080.
- Store sh, addr 0x80000002, WriteDataM=0x1234, mem_ack delayed 3 cycles → mem_wstrb=0xC and mem_wdata=0x12340000 held stable for all 4 req cycles, mem_we=1, then Mvalid=1 and ReadDataM=0.
- Misaligned lw at 0x80000001 → mem_req never asserted, Mvalid=1 one edge after accept, Mfault=1. mem_err on a valid lw → Mfault=1, ReadDataM=0.
- Back-to-back: 3 non-memory instructions, then a load, with Wready held low 2 cycles in DONE:
  - Mvalid held for those 2 cycles, Mready=0, outputs stable.
  - Once Wready=1, the next accept happens the same cycle with no IDLE cycle between results.
- Reset asserted while in REQ → next cycle mem_req=0 and Mvalid=0. A subsequent stray mem_ack produces no Mvalid.
